// File: rtl/matrix_scan_driver_pkg.sv
// Shared definitions for the LED matrix column scanner.
// Holds the matrix geometry, FSM state encoding and the column one-hot helper.
package matrix_scan_driver_pkg;

  localparam int unsigned NumCols = 5;   // physical columns
  localparam int unsigned RowW    = 7;   // rows per column
  localparam int unsigned ColW    = 3;   // width of the column index
  localparam int unsigned CntW    = 16;  // prescale / frame counter width

  // Scan starts at the highest column and walks down to 0.
  localparam logic [ColW-1:0] ColFirst = ColW'(NumCols - 1);

  typedef logic [RowW-1:0] row_t;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StShow
  } scan_state_e;

  function automatic logic [NumCols-1:0] col_onehot(input logic [ColW-1:0] col);
    return NumCols'(1) << col;
  endfunction

endpackage

// File: rtl/matrix_scan_driver_if.sv
// Bundle of the scanner's data-side signals.
//   enable              scan run request
//   column_4..column_0  column images (bit n drives row n)
//   row_out             active-high row drive for the selected column
//   col_sel             one-hot column select
//   selector            alternate-display select (1 = state image, 0 = water level)
//   frame_done          single-cycle pulse at the end of each complete frame
// slave: the scanner; master: whoever supplies images and consumes the drive.
interface matrix_scan_driver_if;
  import matrix_scan_driver_pkg::*;

  logic                 enable;
  row_t                 column_0;
  row_t                 column_1;
  row_t                 column_2;
  row_t                 column_3;
  row_t                 column_4;
  row_t                 row_out;
  logic [NumCols-1:0]   col_sel;
  logic                 selector;
  logic                 frame_done;

  modport slave (
    input  enable, column_0, column_1, column_2, column_3, column_4,
    output row_out, col_sel, selector, frame_done
  );

  modport master (
    output enable, column_0, column_1, column_2, column_3, column_4,
    input  row_out, col_sel, selector, frame_done
  );

endinterface

// File: rtl/matrix_scan_driver_scan_timer.sv
// Prescale and frame counting for the column scanner.
//   clock, reset_n     system clock, asynchronous active-low reset
//   run_i              scan enable; low clears the frame counter
//   show_i             scanner is in SHOW this cycle
//   show_next_i        scanner will be in SHOW next cycle
//   last_col_next_i    column index next cycle is 0
//   slot_end_o         registered: this cycle is the last SHOW cycle of a slot
//   frame_end_o        registered: this cycle is the last SHOW cycle of column 0
//   alt_toggle_o       the selector must invert on the coming edge
module matrix_scan_driver_scan_timer
  import matrix_scan_driver_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 4,
  parameter int unsigned ALT_FRAMES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic run_i,
  input  logic show_i,
  input  logic show_next_i,
  input  logic last_col_next_i,
  output logic slot_end_o,
  output logic frame_end_o,
  output logic alt_toggle_o
);

  logic [CntW-1:0] pre_q, pre_d;
  logic [CntW-1:0] frame_q, frame_d;
  logic            slot_end_q, slot_end_d;
  logic            frame_end_q, frame_end_d;
  logic            frame_wrap;

  // Prescale counts SHOW cycles only; it restarts at 0 on every entry to SHOW.
  always_comb begin
    pre_d = '0;
    if (show_next_i && show_i) begin
      pre_d = pre_q + CntW'(1);
    end
    // Strobes are computed one cycle early so they can be registered outputs.
    slot_end_d  = show_next_i && (pre_d == CntW'(SCAN_DIV - 2));
    frame_end_d = slot_end_d && last_col_next_i;
  end

  assign frame_wrap = frame_q == CntW'(ALT_FRAMES - 1);

  always_comb begin
    frame_d = frame_q;
    if (!run_i) begin
      frame_d = '0;
    end else if (frame_end_q) begin
      frame_d = frame_wrap ? '0 : frame_q + CntW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_q       <= '0;
      frame_q     <= '0;
      slot_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      frame_q     <= frame_d;
      slot_end_q  <= slot_end_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign slot_end_o   = slot_end_q;
  assign frame_end_o  = frame_end_q;
  assign alt_toggle_o = run_i && frame_end_q && frame_wrap;

endmodule

// File: rtl/matrix_scan_driver.sv
// Five-column LED matrix scanner with frame snapshot and alternate-display select.
// Each column slot is one blank cycle followed by SCAN_DIV-1 lit cycles; columns
// are scanned 4..0 from a buffer captured only at frame boundaries.
//   clock, reset_n   system clock, asynchronous active-low reset
//   bus (slave)      enable, column_4..0 in; row_out, col_sel, selector, frame_done out
module matrix_scan_driver
  import matrix_scan_driver_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 4,
  parameter int unsigned ALT_FRAMES = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  matrix_scan_driver_if.slave  bus
);

  scan_state_e        state_q, state_d;
  logic [ColW-1:0]    col_q, col_d;
  row_t               buf_q [NumCols];
  row_t               buf_d [NumCols];
  row_t               cols_in [NumCols];
  logic               capture;
  row_t               row_out_q;
  logic [NumCols-1:0] col_sel_q;
  logic               selector_q;
  logic               slot_end, frame_end, alt_toggle;

  always_comb begin
    cols_in[0] = bus.column_0;
    cols_in[1] = bus.column_1;
    cols_in[2] = bus.column_2;
    cols_in[3] = bus.column_3;
    cols_in[4] = bus.column_4;
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.enable) begin
          state_d = StBlank;
          col_d   = ColFirst;
          capture = 1'b1;
        end
      end
      StBlank: begin
        if (!bus.enable) begin
          state_d = StIdle;
          col_d   = ColFirst;
        end else begin
          state_d = StShow;
        end
      end
      StShow: begin
        if (!bus.enable) begin
          state_d = StIdle;
          col_d   = ColFirst;
        end else if (slot_end) begin
          state_d = StBlank;
          if (col_q == '0) begin
            col_d   = ColFirst;
            capture = 1'b1;
          end else begin
            col_d = col_q - ColW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        col_d   = ColFirst;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < NumCols; i++) begin
      buf_d[i] = capture ? cols_in[i] : buf_q[i];
    end
  end

  matrix_scan_driver_scan_timer #(
    .SCAN_DIV   (SCAN_DIV),
    .ALT_FRAMES (ALT_FRAMES)
  ) scan_timer (
    .clock           (clock),
    .reset_n         (reset_n),
    .run_i           (bus.enable),
    .show_i          (state_q == StShow),
    .show_next_i     (state_d == StShow),
    .last_col_next_i (col_d == '0),
    .slot_end_o      (slot_end),
    .frame_end_o     (frame_end),
    .alt_toggle_o    (alt_toggle)
  );

  // Outputs are registered from next-state values so they line up with state_q.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      col_q      <= ColFirst;
      row_out_q  <= '0;
      col_sel_q  <= '0;
      selector_q <= 1'b1;
      for (int i = 0; i < NumCols; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_out_q <= (state_d == StShow) ? buf_d[col_d] : '0;
      col_sel_q <= (state_d != StIdle) ? col_onehot(col_d) : '0;
      if (alt_toggle) begin
        selector_q <= ~selector_q;
      end
      for (int i = 0; i < NumCols; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  assign bus.row_out    = row_out_q;
  assign bus.col_sel    = col_sel_q;
  assign bus.selector   = selector_q;
  assign bus.frame_done = frame_end;

endmodule

// File: tb/tb_matrix_scan_driver.sv
module tb_matrix_scan_driver;

  localparam int unsigned D = 4;
  localparam int unsigned A = 2;

  typedef struct packed {
    logic [6:0] row;
    logic [4:0] sel;
    logic       selector;
    logic       fd;
  } obs_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  matrix_scan_driver_if bus();

  matrix_scan_driver #(
    .SCAN_DIV   (D),
    .ALT_FRAMES (A)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_total = 0;
  int n_bad = 0;
  int cyc = 0;
  obs_t exp_q[$];

  // Stimulus state
  logic       en;
  logic [6:0] cols [5];

  // Reference model: position inside the current frame plus snapshot
  bit         m_active;
  int         m_pos;
  int         m_frames;
  bit         m_sel;
  logic [6:0] m_buf [5];

  function automatic void model_reset();
    m_active = 0;
    m_pos    = 0;
    m_frames = 0;
    m_sel    = 1;
    for (int i = 0; i < 5; i++) m_buf[i] = '0;
  endfunction

  // Effect of one rising edge with the current inputs.
  function automatic void model_step();
    if (!en) begin
      m_active = 0;
      m_frames = 0;
    end else if (!m_active) begin
      m_active = 1;
      m_pos    = 0;
      for (int i = 0; i < 5; i++) m_buf[i] = cols[i];
    end else if (m_pos == 5 * D - 1) begin
      m_frames++;
      if (m_frames == A) begin
        m_sel    = ~m_sel;
        m_frames = 0;
      end
      m_pos = 0;
      for (int i = 0; i < 5; i++) m_buf[i] = cols[i];
    end else begin
      m_pos++;
    end
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    int c;
    int off;
    o.selector = m_sel;
    o.row = '0;
    o.sel = '0;
    o.fd  = 1'b0;
    if (m_active) begin
      c     = 4 - m_pos / D;
      off   = m_pos % D;
      o.sel = 5'(1 << c);
      o.row = (off == 0) ? 7'h00 : m_buf[c];
      o.fd  = (m_pos == 5 * D - 1);
    end
    return o;
  endfunction

  task automatic tick(input bit rst);
    @(negedge clock);
    bus.enable   = en;
    bus.column_0 = cols[0];
    bus.column_1 = cols[1];
    bus.column_2 = cols[2];
    bus.column_3 = cols[3];
    bus.column_4 = cols[4];
    if (rst) begin
      reset_n = 1'b0;
      model_reset();
      #1;
      n_total++;
      if (bus.row_out !== 7'h00 || bus.col_sel !== 5'b0 || bus.frame_done !== 1'b0 ||
          bus.selector !== 1'b1) begin
        n_bad++;
        $display("FAIL async_reset: got row=%h sel=%b selector=%b fd=%b want 00/00000/1/0",
                 bus.row_out, bus.col_sel, bus.selector, bus.frame_done);
      end
    end else begin
      reset_n = 1'b1;
      model_step();
    end
    exp_q.push_back(model_out());
  endtask

  task automatic wait_pos(input int p, input string name);
    int n;
    n = 0;
    while (!(m_active && m_pos == p) && n < 200) begin
      tick(0);
      n++;
    end
    n_total++;
    if (!(m_active && m_pos == p)) begin
      n_bad++;
      $display("FAIL %s: bound expired, got pos=%0d want pos=%0d", name, m_pos, p);
    end
  endtask

  // Monitor: every cycle, compare DUT outputs against the oldest expectation.
  initial begin
    obs_t e;
    obs_t g;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      g = {bus.row_out, bus.col_sel, bus.selector, bus.frame_done};
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_total++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL outputs cyc=%0d: got row=%h sel=%b selector=%b fd=%b want row=%h sel=%b selector=%b fd=%b",
                   cyc, g.row, g.sel, g.selector, g.fd, e.row, e.sel, e.selector, e.fd);
        end
      end
      n_total++;
      if (!$onehot0(bus.col_sel) || (bus.col_sel == 5'b0 && bus.row_out != 7'h00)) begin
        n_bad++;
        $display("FAIL onehot cyc=%0d: got sel=%b row=%h want one-hot-or-zero, row 0 when idle",
                 cyc, bus.col_sel, bus.row_out);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    en = 1'b0;
    for (int i = 0; i < 5; i++) cols[i] = '0;
    bus.enable   = 1'b0;
    bus.column_0 = '0;
    bus.column_1 = '0;
    bus.column_2 = '0;
    bus.column_3 = '0;
    bus.column_4 = '0;
    model_reset();

    repeat (3) tick(1);

    // Column 4 fully lit, run four frames to see the selector go 1->0->1.
    cols[4] = 7'h7F;
    en = 1'b1;
    repeat (85) tick(0);

    // Change column 2 while column 3 is being shown: must wait for the next frame.
    wait_pos(D + 1, "col3_slot");
    cols[2] = 7'h55;
    repeat (2 * 5 * D) tick(0);

    // Drop enable during column 1 SHOW, then restart.
    wait_pos(3 * D + 1, "col1_show");
    en = 1'b0;
    repeat (5) tick(0);
    en = 1'b1;
    repeat (3 * 5 * D) tick(0);

    // Reset mid-frame while selector is 0.
    begin
      int n;
      n = 0;
      while (!(m_active && m_sel == 0 && m_pos == 7) && n < 400) begin
        tick(0);
        n++;
      end
      n_total++;
      if (!(m_active && m_sel == 0 && m_pos == 7)) begin
        n_bad++;
        $display("FAIL sel0_midframe: bound expired, got sel=%0d pos=%0d want sel=0 pos=7",
                 m_sel, m_pos);
      end
    end
    tick(1);
    tick(1);
    repeat (30) tick(0);

    // Random run, long enough for about a hundred frames.
    for (int k = 0; k < 2400; k++) begin
      if ($urandom_range(3, 0) == 0) cols[$urandom_range(4, 0)] = 7'($urandom);
      if (en) begin
        if ($urandom_range(149, 0) == 0) en = 1'b0;
      end else if ($urandom_range(3, 0) == 0) begin
        en = 1'b1;
      end
      tick($urandom_range(699, 0) == 0);
    end

    en = 1'b0;
    repeat (3) tick(0);
    @(posedge clock);
    #3;
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/matrix_scan_driver.md
MATRIX_SCAN_DRIVER -- requirements
Module: matrix_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4: clock cycles per column slot; legal range 2..65535.
REQ-002 SHALL have parameter ALT_FRAMES, default 2: complete frames per toggle of selector; legal range 1..65535.
REQ-003 SHALL have one clock and asynchronous active-low reset: clock  input  1  rising-edge system clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  scan run request; low means blank the matrix and idle.
REQ-006 column_4 .. column_0  input  7 each  column images for the five physical columns; bit n drives row n.
REQ-007 row_out  output  7  active-high row drive for the currently selected column.
REQ-008 col_sel  output  5  one-hot, active-high column select; bit k selects column_k.
REQ-009 selector  output  1  alternate-display select (1 = state image, 0 = water level), fed back to the display-mode mux.
REQ-010 frame_done  output  1  single-cycle pulse at the end of each complete frame.

Function
REQ-011 SHALL implement states IDLE, BLANK and SHOW, and SHALL hold a column index col (4..0), a prescale counter and a frame counter.
REQ-012 IDLE: col_sel=0, row_out=0, frame_done=0; if enable=1, next state SHALL be BLANK with col=4, and the frame buffer SHALL capture column_4..column_0 on that same edge.
REQ-013 BLANK SHALL last exactly 1 cycle, with col_sel=one-hot(col) and row_out=0 (anti-ghosting); next state SHALL be SHOW with prescale=0.
REQ-014 SHOW SHALL last exactly SCAN_DIV-1 cycles, with col_sel=one-hot(col) and row_out=buffer[col].
REQ-015 Each column slot SHALL therefore be SCAN_DIV cycles long, and one frame SHALL be 5*SCAN_DIV cycles; scan order SHALL be 4,3,2,1,0.
REQ-016 At the last SHOW cycle with col>0, next state SHALL be BLANK with col=col-1.
REQ-017 At the last SHOW cycle with col=0: frame_done SHALL be 1 for that cycle only; col SHALL return to 4; the buffer SHALL re-capture all five inputs; next state SHALL be BLANK.
REQ-018 Input changes SHALL affect the display only at frame boundaries (snapshot); no mid-frame tearing.
REQ-019 The frame counter SHALL increment at each frame_done; when it equals ALT_FRAMES-1 at frame_done, selector SHALL invert and the counter SHALL clear, both on the same edge.
REQ-020 With ALT_FRAMES=1, selector SHALL toggle on every frame_done.
REQ-021 enable=0 in BLANK or SHOW SHALL force next state IDLE, col=4, prescale=0 and frame counter=0; selector SHALL hold its value; a partial frame SHALL NOT pulse frame_done.
REQ-022 All outputs SHALL be registered; col_sel SHALL never have more than one bit set.

Reset
REQ-023 reset_n low SHALL asynchronously force state=IDLE, col=4, prescale=0, frame counter=0, buffer=0, row_out=0, col_sel=0, frame_done=0 and selector=1.
REQ-024 Deassertion SHALL take effect at the next rising clock edge; reset mid-frame SHALL abandon the frame without a frame_done pulse.

Structure
REQ-025 State encodings and the column-count constant (5) SHALL live in the shared matrix package; SCAN_DIV and ALT_FRAMES SHALL remain module parameters.
REQ-026 The prescale/frame counting SHALL be one sub-module, scan_timer, which outputs slot_end and frame_end strobes; the FSM and buffer SHALL stay in matrix_scan_driver.

Verification (SCAN_DIV=4, ALT_FRAMES=2)
REQ-027 Reset then enable=1 with column_4=7'h7F and the others 0 -> cycle 1 BLANK (col_sel=10000, row_out=0); cycles 2-4 row_out=7F; cycle 5 col_sel=01000, row_out=0.
REQ-028 Run continuously -> frame_done pulses every 20 cycles; selector goes 1->0 at the 2nd pulse and 0->1 at the 4th.
REQ-029 Change column_2 from 00 to 55 during the col=3 slot -> the current frame still shows 00 on col 2; the next frame shows 55.
REQ-030 Drop enable during col=1 SHOW -> the next cycle is IDLE with outputs 0 and no frame_done; re-enable -> the scan restarts at col 4, and the frame counter restarts from 0.
REQ-031 Assert reset_n low mid-frame with selector=0 -> all outputs clear immediately and selector=1.
REQ-032 Over a 100-frame random run -> col_sel is always zero or one-hot, and row_out=0 whenever col_sel=0.
